// File: rtl/rx_peak_report_ctrl.sv
// rx_peak_report_ctrl
// Buffers peak reports from the rx peak-identification stage in a small FIFO
// and hands them to the ARM one at a time over the trigger/acquired handshake.
// An unacknowledged report is re-triggered after TIMEOUT enabled clocks, up to
// MAX_RETRY times, and then discarded. Dropped pushes and discarded reports are
// counted in saturating 8-bit statistics.
module rx_peak_report_ctrl #(
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 1024,
   parameter int MAX_RETRY = 3,
   parameter int SAMPLE_W  = 41,
   parameter int TIME_W    = 16,
   parameter int SEQ_W     = 4
) (
   input  logic                        crx_clk,
   input  logic                        rrx_rst,
   input  logic                        erx_en,
   input  logic                        i_peak_valid,
   input  logic signed [SAMPLE_W-1:0]  i_peak_sample,
   input  logic        [SEQ_W-1:0]     i_peak_seq,
   input  logic        [TIME_W-1:0]    i_peak_time,
   input  logic                        iresult_acquired_arm,
   output logic signed [SAMPLE_W-1:0]  o_sample_arm,
   output logic        [SEQ_W-1:0]     o_received_seq,
   output logic        [TIME_W-1:0]    o_time_arm,
   output logic                        o_trigger_arm,
   output logic [$clog2(DEPTH):0]      o_fifo_level,
   output logic [7:0]                  o_overflow_cnt,
   output logic [7:0]                  o_timeout_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;

   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      WAIT_ACK = 2'd2,
      GAP      = 2'd3
   } state_t;

   // Statistics counters stop at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // FIFO storage (data only, no reset needed) and binary read/write counts
   logic signed [SAMPLE_W-1:0] mem_sample [DEPTH];
   logic        [SEQ_W-1:0]    mem_seq    [DEPTH];
   logic        [TIME_W-1:0]   mem_time   [DEPTH];
   logic        [LW-1:0]       wr_cnt;
   logic        [LW-1:0]       rd_cnt;
   logic        [LW-1:0]       level;
   logic                       fifo_full;
   logic                       fifo_empty;

   // Handshake FSM state and its registered side counters
   state_t                     state, state_d;
   logic        [TW-1:0]       timer, timer_d;
   logic        [RW-1:0]       retry, retry_d;
   logic                       trig_d;
   logic                       load;
   logic                       pop;
   logic                       tmo;

   // Push qualification
   logic                       push_req;
   logic                       push_acc;
   logic                       push_drop;

   assign level      = wr_cnt - rd_cnt;
   assign fifo_full  = (level == LEVEL_FULL);
   assign fifo_empty = (level == '0);

   // A pop frees the head slot in the same edge, so a full FIFO can still accept.
   assign push_req  = i_peak_valid & erx_en;
   assign push_acc  = push_req & (~fifo_full | pop);
   assign push_drop = push_req & fifo_full & ~pop;

   assign o_fifo_level = level;

   // Next-state logic: presentation, retry timer and discard decisions
   always_comb begin
      state_d = state;
      timer_d = timer;
      retry_d = retry;
      trig_d  = 1'b0;
      load    = 1'b0;
      pop     = 1'b0;
      tmo     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && erx_en) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            load    = 1'b1;
            timer_d = '0;
            retry_d = '0;
            trig_d  = 1'b1;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            // An ack wins over a simultaneous timeout and is honoured even while disabled.
            if (iresult_acquired_arm) begin
               pop     = 1'b1;
               state_d = GAP;
            end else if (erx_en) begin
               if (timer == TIMER_LAST) begin
                  if (retry < RETRY_MAX) begin
                     retry_d = retry + RW'(1);
                     timer_d = '0;
                     trig_d  = 1'b1;
                  end else begin
                     pop     = 1'b1;
                     tmo     = 1'b1;
                     state_d = GAP;
                  end
               end else begin
                  timer_d = timer + TW'(1);
               end
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers: FSM, counters, FIFO pointers, trigger pulse
   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         state          <= IDLE;
         timer          <= '0;
         retry          <= '0;
         o_trigger_arm  <= 1'b0;
         wr_cnt         <= '0;
         rd_cnt         <= '0;
         o_overflow_cnt <= '0;
         o_timeout_cnt  <= '0;
      end else begin
         state         <= state_d;
         timer         <= timer_d;
         retry         <= retry_d;
         o_trigger_arm <= trig_d;
         if (push_acc) begin
            wr_cnt <= wr_cnt + LW'(1);
         end
         if (pop) begin
            rd_cnt <= rd_cnt + LW'(1);
         end
         if (push_drop) begin
            o_overflow_cnt <= sat_inc(o_overflow_cnt);
         end
         if (tmo) begin
            o_timeout_cnt <= sat_inc(o_timeout_cnt);
         end
      end
   end

   // FIFO write port
   always_ff @(posedge crx_clk) begin
      if (push_acc) begin
         mem_sample[wr_cnt[AW-1:0]] <= i_peak_sample;
         mem_seq[wr_cnt[AW-1:0]]    <= i_peak_seq;
         mem_time[wr_cnt[AW-1:0]]   <= i_peak_time;
      end
   end

   // Presented report: captured from the head on LOAD, held until the next LOAD
   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         o_sample_arm   <= '0;
         o_received_seq <= '0;
         o_time_arm     <= '0;
      end else if (load) begin
         o_sample_arm   <= mem_sample[rd_cnt[AW-1:0]];
         o_received_seq <= mem_seq[rd_cnt[AW-1:0]];
         o_time_arm     <= mem_time[rd_cnt[AW-1:0]];
      end
   end

endmodule

// File: tb/tb_rx_peak_report_ctrl.sv
// tb_rx_peak_report_ctrl
// Directed bench: each expected trigger (data and, where known, the cycle it
// must appear in) is queued by the stimulus; a monitor pops one entry per
// o_trigger_arm pulse and compares. Level/statistics/reset values are checked
// inline at chosen points.
module tb_rx_peak_report_ctrl;

   localparam int DEPTH     = 4;
   localparam int TIMEOUT   = 16;
   localparam int MAX_RETRY = 3;
   localparam int SAMPLE_W  = 41;
   localparam int TIME_W    = 16;
   localparam int SEQ_W     = 4;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        en;
   logic                        pk_valid;
   logic signed [SAMPLE_W-1:0]  pk_sample;
   logic        [SEQ_W-1:0]     pk_seq;
   logic        [TIME_W-1:0]    pk_time;
   logic                        ack;
   logic signed [SAMPLE_W-1:0]  o_sample;
   logic        [SEQ_W-1:0]     o_seq;
   logic        [TIME_W-1:0]    o_time;
   logic                        o_trig;
   logic [$clog2(DEPTH):0]      o_level;
   logic [7:0]                  o_ovf;
   logic [7:0]                  o_tmo;

   logic auto_ack       = 1'b0;
   logic auto_ack_pulse = 1'b0;
   logic man_ack        = 1'b0;
   assign ack = auto_ack_pulse | man_ack;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic signed [SAMPLE_W-1:0] s;
      logic        [SEQ_W-1:0]    q;
      logic        [TIME_W-1:0]   t;
      int                         c;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   rx_peak_report_ctrl #(
      .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY),
      .SAMPLE_W(SAMPLE_W), .TIME_W(TIME_W), .SEQ_W(SEQ_W)
   ) dut (
      .crx_clk(clk),
      .rrx_rst(rst),
      .erx_en(en),
      .i_peak_valid(pk_valid),
      .i_peak_sample(pk_sample),
      .i_peak_seq(pk_seq),
      .i_peak_time(pk_time),
      .iresult_acquired_arm(ack),
      .o_sample_arm(o_sample),
      .o_received_seq(o_seq),
      .o_time_arm(o_time),
      .o_trigger_arm(o_trig),
      .o_fifo_level(o_level),
      .o_overflow_cnt(o_ovf),
      .o_timeout_cnt(o_tmo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   task automatic expect_rep(input logic signed [SAMPLE_W-1:0] s, input logic [SEQ_W-1:0] q,
                             input logic [TIME_W-1:0] t, input int c);
      exp_t e;
      e.s = s;
      e.q = q;
      e.t = t;
      e.c = c;
      sb.push_back(e);
   endtask

   // Called #1 after a clock edge; the report is sampled at the next edge.
   task automatic push(input logic signed [SAMPLE_W-1:0] s, input logic [SEQ_W-1:0] q,
                       input logic [TIME_W-1:0] t);
      pk_valid  = 1'b1;
      pk_sample = s;
      pk_seq    = q;
      pk_time   = t;
      @(posedge clk);
      #1;
      pk_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bounded wait for every queued trigger to be observed.
   task automatic drain(input string name, input int maxc);
      int n;
      n = 0;
      while (sb.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_drain cyc=%0d actual=%0d pending required=0 pending", name, cyc, sb.size());
         sb.delete();
      end
   endtask

   task automatic chk_all_zero(input string name);
      @(negedge clk);
      chk({name, "_sample"}, o_sample, 0);
      chk({name, "_seq"},    o_seq,    0);
      chk({name, "_time"},   o_time,   0);
      chk({name, "_trig"},   o_trig,   0);
      chk({name, "_level"},  o_level,  0);
      chk({name, "_ovf"},    o_ovf,    0);
      chk({name, "_tmo"},    o_tmo,    0);
   endtask

   // Monitor: one queue entry per trigger pulse; also plays the auto-acking ARM.
   initial begin
      forever begin
         @(negedge clk);
         auto_ack_pulse = o_trig & auto_ack;
         if (o_trig) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_trigger cyc=%0d actual=1 required=0", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("trig_sample", o_sample, mon_e.s);
               chk("trig_seq",    o_seq,    mon_e.q);
               chk("trig_time",   o_time,   mon_e.t);
               if (mon_e.c >= 0) chk("trig_cycle", cyc, mon_e.c);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst       = 1'b1;
      en        = 1'b1;
      pk_valid  = 1'b0;
      pk_sample = '0;
      pk_seq    = '0;
      pk_time   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single report, acked in its trigger cycle
      auto_ack = 1'b1;
      t0 = cyc;
      expect_rep(-1234, 12, 500, t0 + 3);
      push(-1234, 12, 500);
      @(negedge clk);
      chk("t1_level_after_push", o_level, 1);
      drain("t1", 20);
      idle(3);
      @(negedge clk);
      chk("t1_level_after_ack", o_level, 0);
      chk("t1_sample_held", o_sample, -1234);

      // Never acked: 4 triggers 16 cycles apart, then discarded
      auto_ack = 1'b0;
      t0 = cyc;
      for (int r = 0; r < 4; r++) expect_rep(-7, 3, 1000, t0 + 3 + 16 * r);
      push(-7, 3, 1000);
      drain("t3", 80);
      idle(20);
      @(negedge clk);
      chk("t3_level", o_level, 0);
      chk("t3_timeout_cnt", o_tmo, 1);
      chk("t3_overflow_cnt", o_ovf, 0);
      chk("t3_sample_held", o_sample, -7);

      // Six back-to-back pushes into a 4-deep FIFO, no acks
      t0 = cyc;
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < 4; r++)
            expect_rep(k + 1, k + 1, 100 + k + 1, t0 + 3 + 67 * k + 16 * r);
      for (int i = 1; i <= 6; i++) push(i, i, 100 + i);
      @(negedge clk);
      chk("t2_level_full", o_level, 4);
      chk("t2_overflow_cnt", o_ovf, 2);
      drain("t2", 300);
      idle(20);
      @(negedge clk);
      chk("t2_level_end", o_level, 0);
      chk("t2_timeout_cnt", o_tmo, 5);

      // Full FIFO: push and ack in the same cycle
      t0 = cyc;
      expect_rep(11, 1, 211, t0 + 3);
      for (int i = 11; i <= 14; i++) push(i, i - 10, 200 + i);
      @(negedge clk);
      chk("t4_level_full", o_level, 4);
      expect_rep(12, 2, 212, -1);
      expect_rep(13, 3, 213, -1);
      expect_rep(14, 4, 214, -1);
      expect_rep(15, 5, 215, -1);
      auto_ack  = 1'b1;
      man_ack   = 1'b1;
      pk_valid  = 1'b1;
      pk_sample = 15;
      pk_seq    = 5;
      pk_time   = 215;
      @(posedge clk);
      #1;
      man_ack  = 1'b0;
      pk_valid = 1'b0;
      @(negedge clk);
      chk("t4_level_push_pop", o_level, 4);
      chk("t4_overflow_same", o_ovf, 2);
      drain("t4", 60);
      idle(5);
      @(negedge clk);
      chk("t4_level_end", o_level, 0);
      chk("t4_last_sample", o_sample, 15);

      // Disabled during WAIT_ACK: timer frozen, strobes ignored, ack still pops
      auto_ack = 1'b0;
      t0 = cyc;
      expect_rep(21, 6, 300, t0 + 3);
      push(21, 6, 300);
      idle(5);
      en = 1'b0;
      for (int j = 0; j < 50; j++) begin
         pk_valid  = (j % 10 == 0);
         pk_sample = 99;
         pk_seq    = 9;
         pk_time   = 999;
         @(posedge clk);
         #1;
      end
      pk_valid = 1'b0;
      @(negedge clk);
      chk("t5_level_frozen", o_level, 1);
      chk("t5_overflow_same", o_ovf, 2);
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      man_ack = 1'b0;
      @(negedge clk);
      chk("t5_level_after_ack", o_level, 0);
      en = 1'b1;
      idle(10);
      @(negedge clk);
      chk("t5_level_end", o_level, 0);
      chk("t5_timeout_same", o_tmo, 5);
      chk("t5_sample_held", o_sample, 21);
      drain("t5", 5);

      // Reset in mid-handshake with three entries queued
      t0 = cyc;
      expect_rep(31, 7, 400, t0 + 3);
      push(31, 7, 400);
      push(32, 7, 401);
      push(33, 7, 402);
      idle(2);
      drain("t6_pre", 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_all_zero("t6_after_reset");
      idle(30);
      @(negedge clk);
      chk("t6_level_quiet", o_level, 0);
      #1;
      auto_ack = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      expect_rep(41, 8, 600, t0 + 3);
      push(41, 8, 600);
      drain("t6_post", 20);
      idle(5);
      @(negedge clk);
      chk("t6_level_end", o_level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
